// File: rtl/stopwatch_counter_n_if.sv
// Bundle of the stopwatch counter's tick, control and display signals.
// The master side drives ticks and controls; the slave side (the counter)
// returns the BCD digits and the status flags.
interface stopwatch_counter_n_if #(
  parameter int NUM_FIELDS = 2,
  parameter int SEL_W      = 3
);
  logic                    oneHz;
  logic                    twoHz;
  logic                    isAdj;
  logic                    isPaused;
  logic                    countDown;
  logic [SEL_W-1:0]        select;
  logic [8*NUM_FIELDS-1:0] digits;
  logic                    rollover;
  logic                    expired;
  logic                    isZero;

  modport master (
    output oneHz, twoHz, isAdj, isPaused, countDown, select,
    input  digits, rollover, expired, isZero
  );

  modport slave (
    input  oneHz, twoHz, isAdj, isPaused, countDown, select,
    output digits, rollover, expired, isZero
  );
endinterface

// File: rtl/stopwatch_counter_n.sv
// Parametrised BCD time counter with NUM_FIELDS two-digit fields.
// Counts up or down on the oneHz run tick, adjusts one selected digit on the
// twoHz adjust tick, and flags rollover, expiry and all-zero.
module stopwatch_counter_n #(
  parameter int NUM_FIELDS   = 2,
  parameter int TENS_MAX     = 5,
  parameter int TOP_TENS_MAX = 5,
  parameter int SEL_W        = 3
) (
  input  logic            refreshClock,
  input  logic            reset,
  stopwatch_counter_n_if.slave bus
);

  localparam int NUM_DIGITS = 2 * NUM_FIELDS;
  localparam int DW         = 4 * NUM_DIGITS;

  // Bit 0 is the first sample, bit 2 the oldest; a tick is bit1 & ~bit2.
  logic [2:0]    r_oneSync;
  logic [2:0]    r_twoSync;
  logic [DW-1:0] r_digits;
  logic          r_rollover;
  logic          r_expired;

  logic          w_oneTick;
  logic          w_twoTick;
  logic          w_update;
  logic          w_allZero;
  logic          w_upCarry;
  logic [DW-1:0] w_runUp;
  logic [DW-1:0] w_runDown;
  logic [DW-1:0] w_adjust;
  logic [DW-1:0] w_nextDigits;
  logic          w_nextRollover;
  logic          w_nextExpired;

  // Largest legal value of digit d: ones are 0..9, tens depend on the field.
  function automatic logic [3:0] digitMax(input int d);
    if (d % 2 == 0) return 4'd9;
    if (d / 2 == NUM_FIELDS - 1) return 4'(TOP_TENS_MAX);
    return 4'(TENS_MAX);
  endfunction

  // An out-of-range digit behaves as if it held its maximum.
  function automatic logic [3:0] clampDigit(input logic [3:0] v, input int d);
    return (v > digitMax(d)) ? digitMax(d) : v;
  endfunction

  // Tick sources are asynchronous; reset preloads the current level so that
  // releasing reset with a source held high does not create a tick.
  always_ff @(posedge refreshClock) begin
    if (reset) begin
      r_oneSync <= {3{bus.oneHz}};
      r_twoSync <= {3{bus.twoHz}};
    end else begin
      r_oneSync <= {r_oneSync[1:0], bus.oneHz};
      r_twoSync <= {r_twoSync[1:0], bus.twoHz};
    end
  end

  assign w_oneTick = r_oneSync[1] & ~r_oneSync[2];
  assign w_twoTick = r_twoSync[1] & ~r_twoSync[2];
  assign w_update  = ~bus.isPaused & (bus.isAdj ? w_twoTick : w_oneTick);
  assign w_allZero = (r_digits == '0);

  // Up-count with carry rippling from the least significant digit.
  always_comb begin
    logic carry;
    logic [3:0] cur;
    w_runUp = r_digits;
    carry   = 1'b1;
    cur     = 4'd0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        cur = clampDigit(r_digits[4*d +: 4], d);
        if (cur == digitMax(d)) begin
          w_runUp[4*d +: 4] = 4'd0;
        end else begin
          w_runUp[4*d +: 4] = cur + 4'd1;
          carry = 1'b0;
        end
      end
    end
    w_upCarry = carry;
  end

  // Down-count with borrow; a digit at 0 reloads its maximum.
  always_comb begin
    logic borrow;
    logic [3:0] cur;
    w_runDown = r_digits;
    borrow    = 1'b1;
    cur       = 4'd0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (borrow) begin
        cur = clampDigit(r_digits[4*d +: 4], d);
        if (cur == 4'd0) begin
          w_runDown[4*d +: 4] = digitMax(d);
        end else begin
          w_runDown[4*d +: 4] = cur - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Adjust touches only the selected digit and wraps inside its own range.
  always_comb begin
    logic [3:0] cur;
    w_adjust = r_digits;
    cur      = 4'd0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (int'(bus.select) == d) begin
        cur = clampDigit(r_digits[4*d +: 4], d);
        if (bus.countDown) begin
          w_adjust[4*d +: 4] = (cur == 4'd0) ? digitMax(d) : cur - 4'd1;
        end else begin
          w_adjust[4*d +: 4] = (cur == digitMax(d)) ? 4'd0 : cur + 4'd1;
        end
      end
    end
  end

  // Choose the next digits and flag pulses according to mode and direction.
  always_comb begin
    w_nextDigits   = r_digits;
    w_nextRollover = 1'b0;
    w_nextExpired  = 1'b0;
    if (w_update) begin
      if (bus.isAdj) begin
        w_nextDigits = w_adjust;
      end else if (!bus.countDown) begin
        w_nextDigits   = w_runUp;
        w_nextRollover = w_upCarry;
      end else if (!w_allZero) begin
        w_nextDigits  = w_runDown;
        w_nextExpired = (w_runDown == '0);
      end
    end
  end

  // Digit and flag registers; the flags are one-cycle pulses.
  always_ff @(posedge refreshClock) begin
    if (reset) begin
      r_digits   <= '0;
      r_rollover <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_digits   <= w_nextDigits;
      r_rollover <= w_nextRollover;
      r_expired  <= w_nextExpired;
    end
  end

  assign bus.digits   = r_digits;
  assign bus.rollover = r_rollover;
  assign bus.expired  = r_expired;
  assign bus.isZero   = w_allZero;

endmodule

// File: tb/tb_stopwatch_counter_n.sv
// Testbench for stopwatch_counter_n: a MM:SS instance and a HH:MM:SS
// instance (top tens 2) share the same stimulus and are compared against a
// mixed-radix arithmetic model of the counter.
module tb_stopwatch_counter_n;

  logic       clk;
  logic       reset;
  logic       oneHz;
  logic       twoHz;
  logic       isAdj;
  logic       isPaused;
  logic       countDown;
  logic [2:0] select;

  int checkCount;
  int passCount;
  int rollCnt [2];
  int expCnt [2];
  int expRoll [2];
  int expExp [2];

  // Model state: digit values per instance, index 0 = ones of field 0.
  int mdl [2][8];
  int nfOf [2]   = '{2, 3};
  int tensOf [2] = '{5, 5};
  int topOf [2]  = '{5, 2};

  typedef struct {
    logic       isAdj;
    logic       countDown;
    logic [2:0] select;
    logic       isPaused;
    logic [15:0] expDigits;
  } vec_t;

  vec_t vecs [14];

  stopwatch_counter_n_if #(.NUM_FIELDS(2), .SEL_W(3)) busA ();
  stopwatch_counter_n_if #(.NUM_FIELDS(3), .SEL_W(3)) busB ();

  assign busA.oneHz     = oneHz;
  assign busA.twoHz     = twoHz;
  assign busA.isAdj     = isAdj;
  assign busA.isPaused  = isPaused;
  assign busA.countDown = countDown;
  assign busA.select    = select;
  assign busB.oneHz     = oneHz;
  assign busB.twoHz     = twoHz;
  assign busB.isAdj     = isAdj;
  assign busB.isPaused  = isPaused;
  assign busB.countDown = countDown;
  assign busB.select    = select;

  stopwatch_counter_n #(
    .NUM_FIELDS(2), .TENS_MAX(5), .TOP_TENS_MAX(5), .SEL_W(3)
  ) dutA (
    .refreshClock(clk),
    .reset(reset),
    .bus(busA.slave)
  );

  stopwatch_counter_n #(
    .NUM_FIELDS(3), .TENS_MAX(5), .TOP_TENS_MAX(2), .SEL_W(3)
  ) dutB (
    .refreshClock(clk),
    .reset(reset),
    .bus(busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count flag pulses once per cycle so a stretched pulse counts twice.
  always @(negedge clk) begin
    if (busA.rollover) rollCnt[0]++;
    if (busB.rollover) rollCnt[1]++;
    if (busA.expired)  expCnt[0]++;
    if (busB.expired)  expCnt[1]++;
  end

  function automatic int radixOf(input int inst, input int d);
    if (d % 2 == 0) return 10;
    if (d / 2 == nfOf[inst] - 1) return topOf[inst] + 1;
    return tensOf[inst] + 1;
  endfunction

  function automatic int valueOf(input int inst);
    int v = 0;
    int w = 1;
    for (int d = 0; d < 2 * nfOf[inst]; d++) begin
      v += mdl[inst][d] * w;
      w *= radixOf(inst, d);
    end
    return v;
  endfunction

  function automatic int capacityOf(input int inst);
    int w = 1;
    for (int d = 0; d < 2 * nfOf[inst]; d++) w *= radixOf(inst, d);
    return w;
  endfunction

  function automatic void setValue(input int inst, input int value);
    int v = value;
    for (int d = 0; d < 2 * nfOf[inst]; d++) begin
      mdl[inst][d] = v % radixOf(inst, d);
      v = v / radixOf(inst, d);
    end
  endfunction

  function automatic logic [31:0] modelDigits(input int inst);
    logic [31:0] res = '0;
    for (int d = 0; d < 2 * nfOf[inst]; d++) res[4*d +: 4] = 4'(mdl[inst][d]);
    return res;
  endfunction

  // Run mode treats the counter as one number modulo its capacity; adjust
  // mode changes one digit modulo its own radix.
  function automatic void modelStep(input int inst, input bit adj, input bit down,
                                    input int sel, output int roll, output int ex);
    int v;
    int r;
    roll = 0;
    ex   = 0;
    if (adj) begin
      if (sel < 2 * nfOf[inst]) begin
        r = radixOf(inst, sel);
        mdl[inst][sel] = down ? (mdl[inst][sel] + r - 1) % r : (mdl[inst][sel] + 1) % r;
      end
    end else if (!down) begin
      v = valueOf(inst) + 1;
      if (v == capacityOf(inst)) begin
        v = 0;
        roll = 1;
      end
      setValue(inst, v);
    end else begin
      v = valueOf(inst);
      if (v != 0) begin
        v--;
        setValue(inst, v);
        if (v == 0) ex = 1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkModel(input string name);
    checkOutput({name, ".digitsA"}, 32'(busA.digits), modelDigits(0));
    checkOutput({name, ".zeroA"}, 32'(busA.isZero), 32'(modelDigits(0) == 0));
    checkOutput({name, ".rollA"}, 32'(rollCnt[0]), 32'(expRoll[0]));
    checkOutput({name, ".expA"}, 32'(expCnt[0]), 32'(expExp[0]));
    checkOutput({name, ".digitsB"}, 32'(busB.digits), modelDigits(1));
    checkOutput({name, ".zeroB"}, 32'(busB.isZero), 32'(modelDigits(1) == 0));
    checkOutput({name, ".rollB"}, 32'(rollCnt[1]), 32'(expRoll[1]));
    checkOutput({name, ".expB"}, 32'(expCnt[1]), 32'(expExp[1]));
  endtask

  // Raise the chosen sources long enough to pass the synchroniser, then drop.
  task automatic pulseSources(input bit one, input bit two);
    oneHz = one;
    twoHz = two;
    repeat (3) @(negedge clk);
    oneHz = 1'b0;
    twoHz = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit adj, input bit down, input int sel, input bit paused);
    int roll;
    int ex;
    isAdj     = adj;
    countDown = down;
    select    = 3'(sel);
    isPaused  = paused;
    pulseSources(!adj, adj);
    if (!paused) begin
      for (int i = 0; i < 2; i++) begin
        modelStep(i, adj, down, sel, roll, ex);
        expRoll[i] += roll;
        expExp[i]  += ex;
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int d = 0; d < 8; d++) mdl[i][d] = 0;
  endtask

  initial begin
    logic [15:0] adjSeq [6];
    int base;
    int roll;
    int ex;

    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    oneHz      = 1'b0;
    twoHz      = 1'b0;
    isAdj      = 1'b0;
    isPaused   = 1'b0;
    countDown  = 1'b0;
    select     = 3'd0;
    for (int i = 0; i < 2; i++) begin
      expRoll[i] = 0;
      expExp[i]  = 0;
      for (int d = 0; d < 8; d++) mdl[i][d] = 0;
    end

    vecs[0]  = '{1'b1, 1'b0, 3'd1, 1'b0, 16'h0010};
    vecs[1]  = '{1'b1, 1'b0, 3'd3, 1'b0, 16'h1010};
    vecs[2]  = '{1'b1, 1'b1, 3'd0, 1'b0, 16'h1019};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 16'h1020};
    vecs[4]  = '{1'b0, 1'b1, 3'd0, 1'b0, 16'h1019};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 16'h1019};
    vecs[6]  = '{1'b1, 1'b1, 3'd2, 1'b0, 16'h1919};
    vecs[7]  = '{1'b0, 1'b1, 3'd0, 1'b0, 16'h1918};
    vecs[8]  = '{1'b1, 1'b0, 3'd4, 1'b0, 16'h1918};
    vecs[9]  = '{1'b1, 1'b0, 3'd7, 1'b0, 16'h1918};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 16'h1919};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 16'h1920};
    vecs[12] = '{1'b1, 1'b1, 3'd3, 1'b0, 16'h0920};
    vecs[13] = '{1'b1, 1'b0, 3'd0, 1'b1, 16'h0920};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    checkOutput("resetDigitsA", 32'(busA.digits), 32'h0);
    checkOutput("resetZeroA", 32'(busA.isZero), 32'h1);
    checkOutput("resetRollA", 32'(busA.rollover), 32'h0);
    checkOutput("resetExpA", 32'(busA.expired), 32'h0);
    checkOutput("resetDigitsB", 32'(busB.digits), 32'h0);

    // Table-driven vectors.
    for (int k = 0; k < 14; k++) begin
      applyStimulus(vecs[k].isAdj, vecs[k].countDown, int'(vecs[k].select), vecs[k].isPaused);
      checkOutput($sformatf("vec%0d", k), 32'(busA.digits), 32'(vecs[k].expDigits));
      checkModel($sformatf("vec%0d", k));
    end

    // Up-count wrap from 59:59 with rollover.
    doReset();
    applyStimulus(1, 1, 3, 0);
    applyStimulus(1, 1, 2, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("preset5958", 32'(busA.digits), 32'h5958);
    base = rollCnt[0];
    applyStimulus(0, 0, 0, 0);
    checkOutput("up5959", 32'(busA.digits), 32'h5959);
    checkOutput("up5959Roll", 32'(rollCnt[0] - base), 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrapDigits", 32'(busA.digits), 32'h0);
    checkOutput("wrapRoll", 32'(rollCnt[0] - base), 32'd1);
    checkOutput("wrapZero", 32'(busA.isZero), 32'h1);
    checkModel("wrap");

    // Down-count borrow and expiry.
    doReset();
    applyStimulus(1, 0, 2, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("down0059", 32'(busA.digits), 32'h0059);
    doReset();
    applyStimulus(1, 0, 0, 0);
    base = expCnt[0];
    applyStimulus(0, 1, 0, 0);
    checkOutput("expireDigits", 32'(busA.digits), 32'h0);
    checkOutput("expirePulse", 32'(expCnt[0] - base), 32'd1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("holdZero", 32'(busA.digits), 32'h0);
    checkOutput("noReExpire", 32'(expCnt[0] - base), 32'd1);
    checkModel("expire");

    // Adjust tens of seconds through its wrap.
    doReset();
    adjSeq = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0000};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, 1, 0);
      checkOutput($sformatf("adjTens%0d", k), 32'(busA.digits), 32'(adjSeq[k]));
    end
    applyStimulus(1, 1, 1, 0);
    checkOutput("adjTensDown", 32'(busA.digits), 32'h0050);

    // Pause drops ticks; unused source is ignored, also when simultaneous.
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("paused", 32'(busA.digits), 32'h0050);
    isAdj = 1'b0;
    countDown = 1'b0;
    select = 3'd3;
    isPaused = 1'b0;
    pulseSources(0, 1);
    checkOutput("twoHzInRun", 32'(busA.digits), 32'h0050);
    pulseSources(1, 1);
    for (int i = 0; i < 2; i++) begin
      modelStep(i, 0, 0, 3, roll, ex);
      expRoll[i] += roll;
      expExp[i]  += ex;
    end
    checkOutput("bothTicks", 32'(busA.digits), 32'h0051);
    checkModel("bothTicks");

    // Tick latency, then reset released with oneHz already high.
    doReset();
    isAdj = 1'b0;
    countDown = 1'b0;
    isPaused = 1'b0;
    oneHz = 1'b1;
    @(posedge clk);
    #1 checkOutput("latencyN", 32'(busA.digits), 32'h0);
    @(posedge clk);
    #1 checkOutput("latencyN1", 32'(busA.digits), 32'h0);
    @(posedge clk);
    #1 checkOutput("latencyN2", 32'(busA.digits), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("resetHeldHigh", 32'(busA.digits), 32'h0);
    oneHz = 1'b0;
    repeat (3) @(negedge clk);
    pulseSources(1, 0);
    checkOutput("afterResetTick", 32'(busA.digits), 32'h1);
    doReset();

    // Three-field instance wraps from 29:59:59; out-of-range select ignored.
    applyStimulus(1, 1, 5, 0);
    applyStimulus(1, 1, 4, 0);
    applyStimulus(1, 1, 3, 0);
    applyStimulus(1, 1, 2, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("presetB", 32'(busB.digits), 32'h295959);
    base = rollCnt[1];
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrapB", 32'(busB.digits), 32'h0);
    checkOutput("wrapBRoll", 32'(rollCnt[1] - base), 32'd1);
    applyStimulus(1, 0, 6, 0);
    applyStimulus(1, 0, 7, 0);
    checkOutput("selOutB", 32'(busB.digits), 32'h0);
    checkModel("fieldsB");

    // Randomised operations against the model.
    doReset();
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), int'($urandom % 8),
                    ($urandom % 8) == 0);
      checkModel($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter_n.md
Name: stopwatch_counter_n

Overview:
Parametrised BCD time counter, the successor to the fixed MM:SS stopwatch counter. It holds NUM_FIELDS two-digit fields, for example MM:SS or HH:MM:SS. It counts up or down on a slow run tick and lets the user adjust one selected digit on a faster adjust tick. It sits between the clock dividers (oneHz/twoHz) and the seven-segment display driver, and adds count-down with expiry, an up-count rollover flag and a zero flag.

Parameters:
NUM_FIELDS, 2, number of two-digit fields (field 0 = least significant); valid range 1..4.
TENS_MAX, 5, maximum tens digit of every field except the top one (5 gives 00..59).
TOP_TENS_MAX, 5, maximum tens digit of the top field; must be 0..9.
SEL_W, 3, width of select; must satisfy 2^SEL_W >= 2*NUM_FIELDS.

Ports:
refreshClock  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
oneHz  in  1  run tick source (asynchronous, slow square wave).
twoHz  in  1  adjust tick source (asynchronous, slow square wave).
isAdj  in  1  1 = adjust mode, 0 = run mode.
isPaused  in  1  1 = ignore all ticks.
countDown  in  1  1 = decrement, 0 = increment (applies to both modes).
select  in  SEL_W  digit index for adjust; 2f = ones of field f, 2f+1 = tens of field f.
digits  out  8*NUM_FIELDS  BCD digits; digit d occupies bits [4d+3:4d], registered.
rollover  out  1  one-cycle pulse when an up-count wraps the full counter to zero.
expired  out  1  one-cycle pulse when a down-count reaches all-zero from non-zero.
isZero  out  1  1 when all digits are 0 (decoded from registers, no extra latency).

Behaviour:
- Tick detection: each tick source passes through three flops s0<=in, s1<=s0, s2<=s1.
  - tick = s1 & ~s2 (rising edge).
  - Latency: in is first sampled high at edge N; the digit update happens at edge N+2.
- Reset (priority over everything):
  - digits, rollover and expired go to 0; isZero reads 1.
  - Sync flops load the current input level (s0=s1=s2=in), so no spurious tick occurs after release.
- Pause: when isPaused=1, ticks are dropped, not queued; digits hold. Sync flops keep sampling.
- Tick source by mode:
  - isAdj=0 uses only the oneHz tick; isAdj=1 uses only the twoHz tick.
  - The unused source's tick is ignored, including when both occur in the same cycle.
  - Mode, countDown and select changes take effect on the next tick.
- Run, up-count:
  - Ones digit 0..9. Tens digit 0..TENS_MAX, or 0..TOP_TENS_MAX in the top field.
  - Carry ripples through all digits within the same cycle.
  - When the counter is at the maximum (e.g. 59:59), the next tick sets all digits to 0 and pulses rollover on that same edge.
- Run, down-count:
  - Borrow ripples; a ones digit at 0 becomes 9; a tens digit at 0 becomes TENS_MAX (TOP_TENS_MAX for the top field).
  - A tick that makes all digits 0 pulses expired on that edge.
  - At all-zero, ticks do nothing: no wrap, no further expired pulse.
- Adjust mode:
  - Only digit[select] changes: +1 if countDown=0, -1 if countDown=1.
  - The change wraps within that digit's range, with no carry or borrow to neighbours.
  - If select >= 2*NUM_FIELDS, nothing changes.
  - rollover and expired are never asserted in adjust mode.
- Out-of-range digits (not reachable from reset): on the next run or adjust update of that digit, treat it as its maximum and apply the normal rules.
- rollover and expired are registered, high for exactly one refreshClock cycle, and 0 otherwise.

Test Plan:
- Run up, NUM_FIELDS=2: preset 59:58 via adjust, then two oneHz rising edges -> 59:59, then 00:00. rollover is high for 1 cycle on the wrap edge; isZero=1.
- Run down: preset 01:00, one oneHz edge -> 00:59. Preset 00:01, then 3 edges -> 00:00 on the first edge with expired pulsed once; digits stay 00:00 after.
- Adjust: isAdj=1, select=1 (tens of seconds), six twoHz edges from 00:00 -> 00:50 then 00:00. Minutes are unchanged. countDown=1 once -> 00:50.
- Pause/priority: isPaused=1 across three oneHz edges -> digits unchanged. oneHz and twoHz rising in the same cycle with isAdj=0 -> only the run increment is applied.
- Latency/reset: oneHz first sampled high at edge N -> digits change at edge N+2. Assert reset with oneHz held high for 2 cycles, then release -> digits 0 and no increment until the next oneHz rising edge.
- NUM_FIELDS=3, TOP_TENS_MAX=2, SEL_W=3: from 29:59:59, one tick -> 00:00:00 with rollover. select=6 or 7 in adjust mode -> no change.
